// File: rtl/coef_table_mc.sv
`timescale 1ns/1ps
// Generic synchronous FIFO with registered storage and head shown combinationally.
// Latency: a push becomes visible at the head on the following cycle.
// Backpressure: pop is ignored when empty; a push while full is taken only alongside a pop.
module fifo #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [W-1:0]         wdat,
    input  logic                 pop,
    output logic [W-1:0]         rdat,
    output logic                 empty,
    output logic [$clog2(D):0]   count
);
    localparam int PW = $clog2(D);

    logic [W-1:0]  mem [D];
    logic [PW-1:0] wp, rp;
    logic          full, wr_en, rd_en;

    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(D));
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign rdat  = mem[rp];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wp] <= wdat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr_en) wp <= wp + 1'b1;
            if (rd_en) rp <= rp + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Multi-channel coefficient ROM front end: round-robin grant, 2-cycle ROM, formatted FIFO output.
// Latency: 3 cycles from request transfer to out_valid when the FIFO is empty.
// Backpressure: grants stop once FIFO occupancy plus reads in flight reaches FD.
module coef_table_mc #(
    parameter int NCH = 2,
    parameter int AW  = 11,
    parameter int CW  = 24,
    parameter int FD  = 4
) (
    input  logic                                 Fg_clk,
    input  logic                                 Resetn,
    input  logic [NCH-1:0]                       req_valid,
    input  logic [NCH*AW-1:0]                    req_addr,
    output logic [NCH-1:0]                       req_ready,
    output logic [AW-1:0]                        rom_ad,
    output logic                                 rom_ce,
    input  logic [2*CW-1:0]                      rom_dout,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] out_ch,
    output logic [31:0]                          sine1x,
    output logic [31:0]                          cos2x
);
    localparam int TW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNTW = $clog2(FD);
    localparam int SW   = CNTW + 2;
    localparam int FW   = TW + 2*CW;

    logic [TW-1:0]   last_q, gnt_idx, rr_c;
    logic            gnt_any, credit_ok;
    logic            v1_q, v2_q;
    logic [TW-1:0]   t1_q, t2_q;
    logic [CNTW:0]   occ;
    logic [SW-1:0]   used;
    logic            f_empty;
    logic [FW-1:0]   f_rdat, head;
    logic [CW-1:0]   sin_f, cos_f;
    logic [27:0]     sin_ext;
    logic [25:0]     cos_ext;

    // Reads already issued to the ROM hold a FIFO slot, so overflow cannot happen.
    assign used      = SW'(occ) + SW'(v1_q) + SW'(v2_q);
    assign credit_ok = Resetn && (used < SW'(FD));

    always_comb begin
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        rr_c      = '0;
        req_ready = '0;
        for (int k = 0; k < NCH; k++) begin
            rr_c = TW'((int'(last_q) + 1 + k) % NCH);
            if (!gnt_any && req_valid[rr_c]) begin
                gnt_any = 1'b1;
                gnt_idx = rr_c;
            end
        end
        if (!credit_ok) gnt_any = 1'b0;
        if (gnt_any) req_ready[gnt_idx] = 1'b1;
    end

    assign rom_ce = gnt_any;
    assign rom_ad = gnt_any ? req_addr[gnt_idx*AW +: AW] : '0;

    always_ff @(posedge Fg_clk or negedge Resetn) begin
        if (!Resetn) begin
            last_q <= TW'(NCH - 1);
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            t1_q   <= '0;
            t2_q   <= '0;
        end else begin
            if (gnt_any) last_q <= gnt_idx;
            v1_q <= gnt_any;
            t1_q <= gnt_idx;
            v2_q <= v1_q;
            t2_q <= t1_q;
        end
    end

    fifo #(.W(FW), .D(FD)) u_fifo (
        .clk   (Fg_clk),
        .rst_n (Resetn),
        .push  (v2_q),
        .wdat  ({t2_q, rom_dout}),
        .pop   (out_ready),
        .rdat  (f_rdat),
        .empty (f_empty),
        .count (occ)
    );

    // Stale storage behind an empty FIFO must not leak onto the outputs.
    assign head      = f_empty ? '0 : f_rdat;
    assign out_valid = !f_empty;
    assign out_ch    = head[FW-1 -: TW];
    assign sin_f     = head[2*CW-1:CW];
    assign cos_f     = head[CW-1:0];
    assign sin_ext   = 28'(sin_f) << (28 - CW);
    assign cos_ext   = 26'(cos_f) << (26 - CW);
    assign sine1x    = {4'b0000, sin_ext};
    assign cos2x     = {6'b001111, cos_ext};
endmodule
